// File: rtl/mips_mem_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding, lane count
// and the address legality check used at request acceptance.
package mips_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    localparam int BYTE_LANES = 4;
    localparam int WAIT_CNT_W = 4;

    // Misaligned byte offset, or any address bit above the word-index field.
    function automatic logic addr_err(input logic [31:0] addr, input int unsigned addr_width);
        logic [31:0] w_hi;
        w_hi = addr >> (addr_width + 2);
        return (addr[1:0] != 2'b00) || (w_hi != 32'd0);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised data storage: synchronous byte-enabled write, combinational
// read from the same index.
module dmem_array
    import mips_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  CLK,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [BYTE_LANES-1:0] i_be,
    input  logic [31:0]           i_wdata,
    output logic [31:0]           o_rdata
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [31:0] r_mem [DEPTH];

    always_ff @(posedge CLK) begin
        if (i_we) begin
            for (int i = 0; i < BYTE_LANES; i++) begin
                if (i_be[i]) begin
                    r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
                end
            end
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/dmem_responder.sv
// Slave end of the core's load/store port: one request at a time, a fixed
// number of wait states, then a held response until the requester takes it.
//
//   state | meaning
//   IDLE  | ReqReady high, waiting for a request
//   WAIT  | request latched, counting down wait states; commit when count is 0
//   RESP  | response held on RespValid/RespRData/RespErr until RespReady
module dmem_responder
    import mips_mem_pkg::*;
#(
    parameter int ADDR_WIDTH  = 6,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        ReqValid,
    output logic        ReqReady,
    input  logic        ReqWrite,
    input  logic [31:0] ReqAddr,
    input  logic [31:0] ReqWData,
    input  logic [3:0]  ReqByteEn,
    output logic        RespValid,
    input  logic        RespReady,
    output logic [31:0] RespRData,
    output logic        RespErr
);

    localparam logic [WAIT_CNT_W-1:0] LP_WAIT_INIT = WAIT_CNT_W'(WAIT_CYCLES);

    dmem_state_t                 r_state;
    logic [WAIT_CNT_W-1:0]       r_wait_cnt;
    logic                        r_write;
    logic                        r_err;
    logic [ADDR_WIDTH-1:0]       r_index;
    logic [31:0]                 r_wdata;
    logic [BYTE_LANES-1:0]       r_be;
    logic                        r_req_ready;
    logic                        r_resp_valid;
    logic [31:0]                 r_resp_rdata;
    logic                        r_resp_err;

    logic                        w_accept;
    logic                        w_commit;
    logic                        w_mem_we;
    logic [31:0]                 w_mem_rdata;

    assign w_accept = ReqValid && r_req_ready;
    assign w_commit = (r_state == WAIT) && (r_wait_cnt == '0);
    // Reset in the commit cycle must suppress the store.
    assign w_mem_we = w_commit && r_write && !r_err && !Reset;

    dmem_array #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_array (
        .CLK     (CLK),
        .i_we    (w_mem_we),
        .i_addr  (r_index),
        .i_be    (r_be),
        .i_wdata (r_wdata),
        .o_rdata (w_mem_rdata)
    );

    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_state      <= IDLE;
            r_wait_cnt   <= '0;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 32'd0;
            r_resp_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_write     <= ReqWrite;
                        r_err       <= addr_err(ReqAddr, ADDR_WIDTH);
                        r_index     <= ReqAddr[ADDR_WIDTH+1:2];
                        r_wdata     <= ReqWData;
                        r_be        <= ReqByteEn;
                        r_wait_cnt  <= LP_WAIT_INIT;
                        r_req_ready <= 1'b0;
                        r_state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (w_commit) begin
                        r_resp_valid <= 1'b1;
                        r_resp_rdata <= (!r_write && !r_err) ? w_mem_rdata : 32'd0;
                        r_resp_err   <= r_err;
                        r_state      <= RESP;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (RespReady) begin
                        r_resp_valid <= 1'b0;
                        r_resp_rdata <= 32'd0;
                        r_resp_err   <= 1'b0;
                        r_req_ready  <= 1'b1;
                        r_state      <= IDLE;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_req_ready <= 1'b1;
                end
            endcase
        end
    end

    assign ReqReady  = r_req_ready;
    assign RespValid = r_resp_valid;
    assign RespRData = r_resp_rdata;
    assign RespErr   = r_resp_err;

endmodule
